// File: rtl/fp_flopoco_pkg.sv
// Shared definitions for the FloPoCo operand encoders: exception-field
// encodings and the width helpers that derive the IEEE-side and
// FloPoCo-side word widths from the exponent and fraction widths.
package fp_flopoco_pkg;

  localparam logic [1:0] EXN_ZERO   = 2'b00;
  localparam logic [1:0] EXN_NORMAL = 2'b01;
  localparam logic [1:0] EXN_INF    = 2'b10;
  localparam logic [1:0] EXN_NAN    = 2'b11;

  // {sign, exp, frac}
  function automatic int fp_in_w(input int we, input int wf);
    return 1 + we + wf;
  endfunction

  // {exn[1:0], sign, exp, frac}
  function automatic int fp_out_w(input int we, input int wf);
    return 3 + we + wf;
  endfunction

endpackage

// File: rtl/fp_pipe_stage.sv
// Generic valid/ready register slice.
// Handshake: a word moves across an interface at a rising clk edge when
// valid && ready are both high there; valid never waits on ready, and the
// data under an asserted valid holds until it is taken.
// in_ready depends only on the stage occupancy and out_ready, never on
// in_valid, so chains of slices give a full-throughput pipeline with no
// combinational path from any valid input.
module fp_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // The slot can be refilled when empty or when its word leaves this cycle.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next occupancy/data: load on advance, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  // Occupancy and data registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/fp_pack_flopoco.sv
// IEEE-style operand to FloPoCo internal format encoder.
// Stage 1 registers the operand with its 2-bit class; stage 2 registers
// the packed word {exn, sign, exp, frac}. Denormals flush to zero, NaNs
// are canonicalised to all-zero payload with exn=11.
// Optional statistics counters are built when FP_PACK_STATS_EN is defined.
module fp_pack_flopoco
  import fp_flopoco_pkg::*;
#(
  parameter int  WE    = 11,
  parameter int  WF    = 1,
  parameter int  CNT_W = 16,
  localparam int IN_W  = fp_in_w(WE, WF),
  localparam int OUT_W = fp_out_w(WE, WF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FP_PACK_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_nan_cnt,
  output logic [CNT_W-1:0] stat_inf_cnt,
  output logic [CNT_W-1:0] stat_flush_cnt
`endif
);

  localparam int S1_W = IN_W + 2;

  // Input field split and classification.
  logic          in_sign;
  logic [WE-1:0] in_exp;
  logic [WF-1:0] in_frac;
  logic [1:0]    in_cls;

  assign {in_sign, in_exp, in_frac} = in_data;

  // Classify the incoming operand from its exponent and fraction fields.
  always_comb begin
    in_cls = EXN_NORMAL;
    if (&in_exp) begin
      in_cls = (|in_frac) ? EXN_NAN : EXN_INF;
    end else if (in_exp == '0) begin
      in_cls = EXN_ZERO;
    end
  end

  // Stage 1: registered operand plus class.
  logic            s1_valid;
  logic            s2_in_ready;
  logic [S1_W-1:0] s1_data;

  fp_pipe_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_cls, in_data}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  logic [1:0]    s1_cls;
  logic          s1_sign;
  logic [WE-1:0] s1_exp;
  logic [WF-1:0] s1_frac;

  assign {s1_cls, s1_sign, s1_exp, s1_frac} = s1_data;

  // Packing of the stage-1 operand according to its class.
  logic          pk_sign;
  logic [WE-1:0] pk_exp;
  logic [WF-1:0] pk_frac;

  // Normals pass through; zero/inf keep only the sign; NaN is all-zero.
  always_comb begin
    pk_sign = s1_sign;
    pk_exp  = s1_exp;
    pk_frac = s1_frac;
    if (s1_cls == EXN_NAN) begin
      pk_sign = 1'b0;
      pk_exp  = '0;
      pk_frac = '0;
    end else if (s1_cls != EXN_NORMAL) begin
      pk_exp  = '0;
      pk_frac = '0;
    end
  end

  // Stage 2: packed FloPoCo word presented downstream.
  fp_pipe_stage #(.W(OUT_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   ({s1_cls, pk_sign, pk_exp, pk_frac}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

`ifdef FP_PACK_STATS_EN
  // Saturating per-class counters, stepped on each stage1 -> stage2 move.
  logic             s12_xfer;
  logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;
  logic [CNT_W-1:0] inf_cnt_q, inf_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign s12_xfer       = s1_valid && s2_in_ready;
  assign stat_nan_cnt   = nan_cnt_q;
  assign stat_inf_cnt   = inf_cnt_q;
  assign stat_flush_cnt = flush_cnt_q;

  // Clear wins over increment; increments stop at all-ones.
  always_comb begin
    nan_cnt_d   = nan_cnt_q;
    inf_cnt_d   = inf_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stat_clr) begin
      nan_cnt_d   = '0;
      inf_cnt_d   = '0;
      flush_cnt_d = '0;
    end else if (s12_xfer) begin
      if (s1_cls == EXN_NAN && !(&nan_cnt_q)) begin
        nan_cnt_d = nan_cnt_q + CNT_W'(1);
      end
      if (s1_cls == EXN_INF && !(&inf_cnt_q)) begin
        inf_cnt_d = inf_cnt_q + CNT_W'(1);
      end
      // Only real denormals count; exact zeros have a zero fraction.
      if (s1_cls == EXN_ZERO && (|s1_frac) && !(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_cnt_q   <= '0;
      inf_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      nan_cnt_q   <= nan_cnt_d;
      inf_cnt_q   <= inf_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
`else
  // Counter width only matters when the statistics block is built.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_fp_pack_flopoco.sv
// Testbench for fp_pack_flopoco: directed vectors, backpressure, reset
// mid-stream and a randomized stream, checked by a scoreboard queue.
// Statistics checks are compiled when FP_PACK_STATS_EN is defined.
module tb_fp_pack_flopoco;
  localparam int WE    = 11;
  localparam int WF    = 1;
  localparam int IN_W  = 1 + WE + WF;
  localparam int OUT_W = 3 + WE + WF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;

`ifdef FP_PACK_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_nan_cnt, stat_inf_cnt, stat_flush_cnt;
  logic [1:0]  sat_nan_cnt, sat_inf_cnt, sat_flush_cnt;
  logic [OUT_W-1:0] sat_out_data;
  logic        sat_out_valid, sat_in_ready;
`endif

  fp_pack_flopoco #(.WE(WE), .WF(WF), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FP_PACK_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_nan_cnt   (stat_nan_cnt),
    .stat_inf_cnt   (stat_inf_cnt),
    .stat_flush_cnt (stat_flush_cnt)
`endif
  );

`ifdef FP_PACK_STATS_EN
  // Narrow-counter copy fed with every word the main instance accepts.
  fp_pack_flopoco #(.WE(WE), .WF(WF), .CNT_W(2)) u_sat (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid && in_ready),
    .in_ready       (sat_in_ready),
    .out_data       (sat_out_data),
    .out_valid      (sat_out_valid),
    .out_ready      (1'b1),
    .stat_clr       (1'b0),
    .stat_nan_cnt   (sat_nan_cnt),
    .stat_inf_cnt   (sat_inf_cnt),
    .stat_flush_cnt (sat_flush_cnt)
  );
`endif

  // ---------------- scoreboard state ----------------
  logic [OUT_W-1:0] exp_q[$];
  logic [IN_W-1:0]  in_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int main_nan = 0, main_inf = 0, main_flush = 0;
  int tot_nan  = 0, tot_inf  = 0, tot_flush  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [OUT_W-1:0] ref_pack(input logic [IN_W-1:0] x);
    int v, s, e, f, r;
    v = int'(x);
    s = v >> (WE + WF);
    e = (v >> WF) % (1 << WE);
    f = v % (1 << WF);
    if (e == (1 << WE) - 1) begin
      if (f != 0) r = 3 << (WE + WF + 1);
      else        r = (2 << (WE + WF + 1)) + (s << (WE + WF));
    end else if (e == 0) begin
      r = s << (WE + WF);
    end else begin
      r = (1 << (WE + WF + 1)) + v;
    end
    return OUT_W'(r);
  endfunction

  // 1 = NaN, 2 = infinity, 3 = denormal, 0 = anything else
  function automatic int stat_class(input logic [IN_W-1:0] x);
    int v, e, f;
    v = int'(x);
    e = (v >> WF) % (1 << WE);
    f = v % (1 << WF);
    if (e == (1 << WE) - 1) return (f != 0) ? 1 : 2;
    if (e == 0 && f != 0) return 3;
    return 0;
  endfunction

  function automatic logic [IN_W-1:0] mk_in(input int s, input int e, input int f);
    return IN_W'((s << (WE + WF)) + (e << WF) + f);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h, expected no output at %0t", out_data, $time);
      end else if (out_ready) begin
        int c;
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        c = stat_class(in_q.pop_front());
        if (c == 1) begin main_nan++;   tot_nan++;   end
        if (c == 2) begin main_inf++;   tot_inf++;   end
        if (c == 3) begin main_flush++; tot_flush++; end
      end else begin
        chk("stall_hold", 32'(out_data), 32'(exp_q[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [IN_W-1:0] d, input logic [OUT_W-1:0] e);
    bit done;
    done = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        in_q.push_back(d);
        n_acc++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed tables ----------------
  logic [IN_W-1:0]  dir_in[6]  = '{13'h0FFE, 13'h1FFE, 13'h1FFF, 13'h0001, 13'h1001, 13'h0000};
  logic [OUT_W-1:0] dir_out[6] = '{15'h4000, 15'h5000, 15'h6000, 15'h0000, 15'h1000, 15'h0000};
  logic [IN_W-1:0]  bp_in[4]   = '{13'h0002, 13'h0004, 13'h0006, 13'h0008};
  logic [OUT_W-1:0] bp_out[4]  = '{15'h2002, 15'h2004, 15'h2006, 15'h2008};

  bit rnd_done;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // +1.0 with two-edge latency
    out_ready = 1'b1;
    send(13'h07FE, 15'h27FE);
    @(negedge clk);
    chk("lat_first_edge", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_second_edge", 32'(out_valid), 32'd1);
    chk("plus_one", 32'(out_data), 32'h27FE);
    @(posedge clk);
    #1;
    drain();

    // specials and flushes, back-to-back
    for (int i = 0; i < 6; i++) send(dir_in[i], dir_out[i]);
    drain();

    // backpressure
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp_in[i], bp_out[i]);
      end
      begin
        for (int i = 0; i < 50 && n_acc < 2; i++) @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_data_head", 32'(out_data), 32'h2002);
        chk("bp_accepts", 32'(n_acc), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with both stages full
    out_ready = 1'b0;
    send(13'h0002, 15'h2002);
    send(13'h0004, 15'h2004);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    in_q.delete();
    main_nan = 0; main_inf = 0; main_flush = 0;
    tot_nan  = 0; tot_inf  = 0; tot_flush  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // randomized stream with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          int sel, e;
          logic [IN_W-1:0] d;
          sel = $urandom_range(0, 7);
          if (sel == 0)      e = (1 << WE) - 1;
          else if (sel == 1) e = 0;
          else               e = $urandom_range(1, (1 << WE) - 2);
          d = mk_in($urandom_range(0, 1), e, $urandom_range(0, (1 << WF) - 1));
          send(d, ref_pack(d));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

`ifdef FP_PACK_STATS_EN
    // counters against the model counts since the last reset
    send(mk_in(0, (1 << WE) - 1, 1), 15'h6000);
    send(mk_in(1, (1 << WE) - 1, 1), 15'h6000);
    send(mk_in(0, (1 << WE) - 1, 1), 15'h6000);
    send(mk_in(0, (1 << WE) - 1, 0), 15'h4000);
    send(mk_in(1, (1 << WE) - 1, 0), 15'h5000);
    send(mk_in(0, 0, 1), 15'h0000);
    send(mk_in(0, 0, 0), 15'h0000);
    drain();
    chk("stat_nan", 32'(stat_nan_cnt), 32'(main_nan));
    chk("stat_inf", 32'(stat_inf_cnt), 32'(main_inf));
    chk("stat_flush", 32'(stat_flush_cnt), 32'(main_flush));

    // clear coinciding with a NaN moving into stage 2
    send(mk_in(1, (1 << WE) - 1, 1), 15'h6000);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    drain();
    main_nan = 0; main_inf = 0; main_flush = 0;
    chk("stat_clr_nan", 32'(stat_nan_cnt), 32'(main_nan));
    chk("stat_clr_inf", 32'(stat_inf_cnt), 32'(main_inf));
    chk("stat_clr_flush", 32'(stat_flush_cnt), 32'(main_flush));

    // saturation on the 2-bit copy
    send(mk_in(0, (1 << WE) - 1, 1), 15'h6000);
    send(mk_in(0, (1 << WE) - 1, 1), 15'h6000);
    drain();
    chk("stat_after_clr_nan", 32'(stat_nan_cnt), 32'(main_nan));
    chk("sat_nan", 32'(sat_nan_cnt), 32'((tot_nan > 3) ? 3 : tot_nan));
    chk("sat_inf", 32'(sat_inf_cnt), 32'((tot_inf > 3) ? 3 : tot_inf));
    chk("sat_flush", 32'(sat_flush_cnt), 32'((tot_flush > 3) ? 3 : tot_flush));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
